// File: rtl/seq_adder_if.sv
// Operand/result valid-ready bundle for seq_adder.
// The sub field exists only when SEQ_ADDER_SUB_EN is defined.
interface seq_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
`ifdef SEQ_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

`ifdef SEQ_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
`endif
endinterface

// File: rtl/seq_adder.sv
// Multi-cycle ripple adder, DIGIT bits per clock, registered carry.
// Define SEQ_ADDER_SUB_EN to add the subtract-select input.
module seq_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_adder_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sub_w;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;

`ifdef SEQ_ADDER_SUB_EN
  assign sub_w = bus.sub;
`else
  assign sub_w = 1'b0;
`endif

  // operands shift right each cycle, so the live digit is always the LSBs
  assign dsum = {1'b0, a_q[DIGIT-1:0]}
              + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1]
                 ^ dsum[DIGIT-1];

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = sub_w ? ~bus.b : bus.b;
          carry_d = bus.ci ^ sub_w;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // digits enter at the top and drift down to their final place
        acc_d   = (acc_q >> DIGIT)
                | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = acc_d;
          cout_d  = dsum[DIGIT];
          ovf_d   = msb_cin ^ dsum[DIGIT];
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/seq_adder.md
# seq_adder

Parametrised multi-cycle ripple adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered inter-digit carry. Successor to the single-bit full adder, sitting between operand producers and result consumers in the datapath with valid/ready handshakes on both sides. Trades latency for a short critical path (one DIGIT-bit ripple per cycle).

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH; NDIG = WIDTH/DIGIT
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in (borrow-in when sub=1)
- sub  in  1  subtract select; present only with SEQ_ADDER_SUB_EN
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum/difference
- cout  out  1  carry out of MSB
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1, out_valid=0. On in_valid & in_ready: latch a, b (b inverted if sub), carry register = ci (or ~ci if sub), digit counter = 0, → RUN.
- RUN: in_ready=0. Each cycle add digit[counter] of a, b with carry register; write digit into internal accumulator; carry register = digit carry-out; counter++. On last digit (counter = NDIG-1): load s from accumulator+final digit, cout, ovf; → DONE.
- DONE: out_valid=1, in_ready=0. On out_ready: → IDLE. in_valid ignored in RUN and DONE (operands not sampled).
- s, cout, ovf change only on the RUN→DONE edge; stable while out_valid=1 and held after handshake until next result.
- Sub mode result: s = a − b − ci; cout=1 means no borrow.
- Arithmetic modulo 2^WIDTH; no saturation.
- Reset mid-operation: abort immediately, discard operands and partial sum, all outputs to reset values.

## Timing
- Reset values: in_ready=1, out_valid=0, s=0, cout=0, ovf=0; internal carry/counter=0.
- Accept on edge E; digits computed on edges E+1..E+NDIG; out_valid=1 from edge E+NDIG.
- Handshake at edge H (out_valid & out_ready) → in_ready=1 from H; next accept earliest H+1. Peak throughput one op per NDIG+2 cycles.
- out_ready high on arrival: out_valid is high for exactly one cycle.
- DIGIT=WIDTH (NDIG=1): RUN lasts one cycle, same rules.
- Critical path: one DIGIT-bit ripple plus carry register.

## Configuration
- SEQ_ADDER_SUB_EN defined: sub port exists; sub sampled with operands at accept; sub=1 inverts b and carry-in as above.
- Undefined: no sub port; block is add-only; all else identical.

## Test plan
- WIDTH=8, DIGIT=2: a=0x5A, b=0x3C, ci=0 accepted edge E → out_valid at E+4, s=0x96, cout=0, ovf=1.
- WIDTH=8, DIGIT=2: a=0xFF, b=0x01, ci=1 → s=0x01, cout=1, ovf=0.
- Backpressure: out_ready=0 for 10 cycles after result → out_valid, s, cout, ovf stable, in_ready=0; in_valid pulses with other operands have no effect; out_ready=1 → in_ready=1 next cycle.
- Reset asserted after 2 RUN cycles → asynchronously out_valid=0, in_ready=1, s=0; after release a new add completes with correct result.
- SEQ_ADDER_SUB_EN, WIDTH=8, DIGIT=2: sub=1, a=0x10, b=0x20, ci=0 → s=0xF0, cout=0, ovf=0.
- WIDTH=1, DIGIT=1: all 8 (a,b,ci) combos → s, cout match full-adder truth table; out_valid at E+1 each time.
